// File: rtl/id_ex_reg_if.sv
// ID/EX pipeline-register bus: ID-stage fields in, registered EX-stage fields and
// load-use stall status out.
interface id_ex_reg_if #(
  parameter int CNT_W = 32
);
  logic             flush;
  logic [31:0]      instruction_ID;
  logic [31:0]      pc_ID;
  logic [31:0]      RD1_id;
  logic [31:0]      dram_data;
  logic [31:0]      imm_id;
  logic             reg_we_id;
  logic             mem_we_id;
  logic             mem_re_id;
  logic [1:0]       wb_sel_id;
  logic [3:0]       alu_op_id;

  logic [31:0]      instruction_EX;
  logic [31:0]      pc_EX;
  logic [31:0]      RD1_ex;
  logic [31:0]      store_data_ex;
  logic [31:0]      imm_ex;
  logic [4:0]       rd_ex;
  logic             reg_we_ex;
  logic             mem_we_ex;
  logic             mem_re_ex;
  logic [1:0]       wb_sel_ex;
  logic [3:0]       alu_op_ex;
  logic             valid_ex;
  logic             stall;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output flush, instruction_ID, pc_ID, RD1_id, dram_data, imm_id,
           reg_we_id, mem_we_id, mem_re_id, wb_sel_id, alu_op_id,
    input  instruction_EX, pc_EX, RD1_ex, store_data_ex, imm_ex, rd_ex,
           reg_we_ex, mem_we_ex, mem_re_ex, wb_sel_ex, alu_op_ex,
           valid_ex, stall, stall_cnt
  );

  modport slave (
    input  flush, instruction_ID, pc_ID, RD1_id, dram_data, imm_id,
           reg_we_id, mem_we_id, mem_re_id, wb_sel_id, alu_op_id,
    output instruction_EX, pc_EX, RD1_ex, store_data_ex, imm_ex, rd_ex,
           reg_we_ex, mem_we_ex, mem_re_ex, wb_sel_ex, alu_op_ex,
           valid_ex, stall, stall_cnt
  );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use hazard detection: inserts a one-cycle
// bubble for load-use pairs, a bubble on flush, and counts stall cycles.
module id_ex_reg #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  id_ex_reg_if.slave  bus
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  logic [31:0]      r_instr;
  logic [31:0]      r_pc;
  logic [31:0]      r_rd1;
  logic [31:0]      r_store_data;
  logic [31:0]      r_imm;
  logic [4:0]       r_rd;
  logic             r_reg_we;
  logic             r_mem_we;
  logic             r_mem_re;
  logic [1:0]       r_wb_sel;
  logic [3:0]       r_alu_op;
  logic             r_valid;
  logic [CNT_W-1:0] r_stall_cnt;

  logic [6:0]       w_opcode;
  logic [4:0]       w_rs1;
  logic [4:0]       w_rs2;
  logic             w_uses_rs1;
  logic             w_uses_rs2;
  logic             w_hit_rs1;
  logic             w_hit_rs2;
  logic             w_load_use;
  logic             w_stall;
  logic             w_bubble;

  logic [31:0]      w_instr_next;
  logic [31:0]      w_pc_next;
  logic [31:0]      w_rd1_next;
  logic [31:0]      w_store_data_next;
  logic [31:0]      w_imm_next;
  logic [4:0]       w_rd_next;
  logic             w_reg_we_next;
  logic             w_mem_we_next;
  logic             w_mem_re_next;
  logic [1:0]       w_wb_sel_next;
  logic [3:0]       w_alu_op_next;
  logic             w_valid_next;
  logic [CNT_W-1:0] w_stall_cnt_next;

  // ID-stage operand decode
  assign w_opcode = bus.instruction_ID[6:0];
  assign w_rs1    = bus.instruction_ID[19:15];
  assign w_rs2    = bus.instruction_ID[24:20];

  assign w_uses_rs1 = !((w_opcode == OPC_LUI) || (w_opcode == OPC_AUIPC) ||
                        (w_opcode == OPC_JAL));
  assign w_uses_rs2 = (w_opcode == OPC_OP) || (w_opcode == OPC_STORE) ||
                      (w_opcode == OPC_BRANCH);

  assign w_hit_rs1 = w_uses_rs1 && (r_rd == w_rs1);
  assign w_hit_rs2 = w_uses_rs2 && (r_rd == w_rs2);

  // Only a real load in EX writing a nonzero register can create the hazard;
  // the bubble it causes clears mem_re, so the stall never exceeds one cycle.
  assign w_load_use = r_valid && r_mem_re && (r_rd != 5'd0) &&
                      (w_hit_rs1 || w_hit_rs2);

  // A flushed ID instruction is dead anyway, so it must not hold the front end.
  assign w_stall  = w_load_use && !bus.flush;
  assign w_bubble = bus.flush || w_stall;

  always_comb begin
    w_instr_next      = bus.instruction_ID;
    w_pc_next         = bus.pc_ID;
    w_rd1_next        = bus.RD1_id;
    w_store_data_next = bus.dram_data;
    w_imm_next        = bus.imm_id;
    w_rd_next         = bus.instruction_ID[11:7];
    w_reg_we_next     = bus.reg_we_id;
    w_mem_we_next     = bus.mem_we_id;
    w_mem_re_next     = bus.mem_re_id;
    w_wb_sel_next     = bus.wb_sel_id;
    w_alu_op_next     = bus.alu_op_id;
    w_valid_next      = 1'b1;
    if (w_bubble) begin
      w_instr_next      = NOP_INSTR;
      w_pc_next         = 32'd0;
      w_rd1_next        = 32'd0;
      w_store_data_next = 32'd0;
      w_imm_next        = 32'd0;
      w_rd_next         = 5'd0;
      w_reg_we_next     = 1'b0;
      w_mem_we_next     = 1'b0;
      w_mem_re_next     = 1'b0;
      w_wb_sel_next     = 2'd0;
      w_alu_op_next     = 4'd0;
      w_valid_next      = 1'b0;
    end
  end

  // Wraps naturally modulo 2^CNT_W
  assign w_stall_cnt_next = w_stall ? (r_stall_cnt + CNT_W'(1)) : r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr      <= NOP_INSTR;
      r_pc         <= 32'd0;
      r_rd1        <= 32'd0;
      r_store_data <= 32'd0;
      r_imm        <= 32'd0;
      r_rd         <= 5'd0;
      r_reg_we     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_re     <= 1'b0;
      r_wb_sel     <= 2'd0;
      r_alu_op     <= 4'd0;
      r_valid      <= 1'b0;
      r_stall_cnt  <= '0;
    end else begin
      r_instr      <= w_instr_next;
      r_pc         <= w_pc_next;
      r_rd1        <= w_rd1_next;
      r_store_data <= w_store_data_next;
      r_imm        <= w_imm_next;
      r_rd         <= w_rd_next;
      r_reg_we     <= w_reg_we_next;
      r_mem_we     <= w_mem_we_next;
      r_mem_re     <= w_mem_re_next;
      r_wb_sel     <= w_wb_sel_next;
      r_alu_op     <= w_alu_op_next;
      r_valid      <= w_valid_next;
      r_stall_cnt  <= w_stall_cnt_next;
    end
  end

  assign bus.instruction_EX = r_instr;
  assign bus.pc_EX          = r_pc;
  assign bus.RD1_ex         = r_rd1;
  assign bus.store_data_ex  = r_store_data;
  assign bus.imm_ex         = r_imm;
  assign bus.rd_ex          = r_rd;
  assign bus.reg_we_ex      = r_reg_we;
  assign bus.mem_we_ex      = r_mem_we;
  assign bus.mem_re_ex      = r_mem_re;
  assign bus.wb_sel_ex      = r_wb_sel;
  assign bus.alu_op_ex      = r_alu_op;
  assign bus.valid_ex       = r_valid;
  assign bus.stall          = w_stall;
  assign bus.stall_cnt      = r_stall_cnt;

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 Parameter NOP_INSTR, 32'h0000_0013, instruction word inserted for bubbles (addi x0,x0,0).
REQ-002 Parameter CNT_W, 32, width of stall performance counter.
REQ-003 clk  in  1  single pipeline clock, all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 flush  in  1  EX-stage branch/jump taken; kill instruction entering EX.
REQ-006 instruction_ID  in  32  instruction in ID.
REQ-007 pc_ID  in  32  PC of ID instruction.
REQ-008 RD1_id  in  32  register-file read data 1.
REQ-009 dram_data  in  32  store data after S-type forwarding.
REQ-010 imm_id  in  32  decoded immediate.
REQ-011 reg_we_id, mem_we_id, mem_re_id  in  1 each  regfile write, DRAM write, load.
REQ-012 wb_sel_id  in  2  write-back source select; alu_op_id  in  4  ALU operation.
REQ-013 instruction_EX, pc_EX, RD1_ex, store_data_ex, imm_ex  out  32 each  registered copies.
REQ-014 rd_ex  out  5  destination register in EX (instruction_EX[11:7], 0 for bubble).
REQ-015 reg_we_ex, mem_we_ex, mem_re_ex  out  1 each; wb_sel_ex  out  2; alu_op_ex  out  4.
REQ-016 valid_ex  out  1  EX holds a real instruction.
REQ-017 stall  out  1  combinational; hold PC and IF/ID this cycle.
REQ-018 stall_cnt  out  CNT_W  number of load-use stall cycles since reset.

Function
REQ-019 rs1_id = instruction_ID[19:15], rs2_id = instruction_ID[24:20], opcode_id = instruction_ID[6:0].
REQ-020 uses_rs1 SHALL be 1 except for opcodes 0110111 (LUI), 0010111 (AUIPC), 1101111 (JAL).
REQ-021 uses_rs2 SHALL be 1 only for opcodes 0110011 (R), 0100011 (S), 1100011 (B).
REQ-022 load_use = valid_ex & mem_re_ex & (rd_ex != 0) & ((uses_rs1 & rd_ex == rs1_id) | (uses_rs2 & rd_ex == rs2_id)).
REQ-023 stall SHALL equal load_use & ~flush (flush squashes the ID instruction, so no stall).
REQ-024 Each edge, exactly one action, priority: flush > stall > load.
REQ-025 Flush or stall: insert bubble -- instruction_EX = NOP_INSTR, valid_ex = 0, rd_ex = 0, reg_we/mem_we/mem_re = 0, wb_sel = 0, alu_op = 0, pc/RD1/store_data/imm = 0.
REQ-026 Load: all *_ex outputs take ID inputs; valid_ex = 1; rd_ex = instruction_ID[11:7]; store_data_ex = dram_data.
REQ-027 Latency SHALL be one cycle ID -> EX; no combinational path from ID inputs to *_ex outputs.
REQ-028 A stalled ID instruction SHALL be loaded the cycle after the bubble (stall lasts exactly one cycle per load-use pair, because the bubble clears mem_re_ex).
REQ-029 stall_cnt SHALL increment by 1 on each edge where stall = 1; wraps modulo 2^CNT_W from all-ones to 0.
REQ-030 flush and load_use in the same cycle: bubble inserted, stall = 0, stall_cnt unchanged.

Reset
REQ-031 rst_n low SHALL immediately (without clock) force all *_ex outputs to bubble values (REQ-025), valid_ex = 0, stall_cnt = 0.
REQ-032 stall SHALL be 0 while in reset (valid_ex = 0).
REQ-033 Reset asserted mid-stall SHALL discard the pending instruction; first edge after release performs normal load.

Verification
REQ-034 Reset: rst_n=0 asynchronously mid-cycle -> instruction_EX=32'h00000013, valid_ex=0, stall_cnt=0 before next edge.
REQ-035 Pass-through: instruction_ID=32'h002081B3 (add x3,x1,x2), pc_ID=32'h100 -> next cycle instruction_EX=32'h002081B3, rd_ex=3, pc_EX=32'h100, valid_ex=1, stall=0.
REQ-036 Load-use: EX=lw x5 (mem_re_ex=1, rd_ex=5), ID=sw x5,0(x6) (32'h00532023) -> stall=1, next cycle bubble, stall_cnt=1, following cycle sw enters EX with store_data_ex=dram_data.
REQ-037 No false stall: EX=lw x5, ID=lui x5,1 (32'h000012B7) -> stall=0, lui loaded; EX=lw x0 -> stall=0.
REQ-038 Flush priority: flush=1 with load_use active -> stall=0, bubble inserted, stall_cnt unchanged.
REQ-039 Counter wrap: preload via CNT_W=4 build, 16 stall cycles -> stall_cnt returns to 0.
